run_sequencer: RTL and testbench

Sequencer for one processor run. It sits directly upstream of the processor core's `req`/`done` pins and shares the core's data memory port. It streams an input byte block into data memory, pulses the core's reset, and holds `req` until `done` or a timeout. It then streams a result block back out of data memory to the host.

---
 rtl/run_sequencer_if.sv | 34 +++
 rtl/run_sequencer.sv | 119 +++++++++++
 tb/tb_run_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_sequencer_if.sv
// Host, data-memory and core-control signals of the run sequencer.
// slave is the sequencer side; master is the host/core/memory side.
interface run_sequencer_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_sel;
    logic       mem_wr_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_wr_dat;
    logic [7:0] mem_rd_dat;
    logic       core_reset;
    logic       core_req;
    logic       core_done;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       finished;
    logic       timeout;

    modport slave (
        input  start, in_valid, in_data, mem_rd_dat, core_done, out_ready,
        output in_ready, mem_sel, mem_wr_en, mem_addr, mem_wr_dat,
               core_reset, core_req, out_valid, out_data, busy, finished, timeout
    );

    modport master (
        output start, in_valid, in_data, mem_rd_dat, core_done, out_ready,
        input  in_ready, mem_sel, mem_wr_en, mem_addr, mem_wr_dat,
               core_reset, core_req, out_valid, out_data, busy, finished, timeout
    );
endinterface

// File: rtl/run_sequencer.sv
// One core run: load input block, pulse core reset, hold req until done/timeout, stream results out.
// start->in_ready 1 cycle, done->out_valid 2 cycles; load stalls on in_valid, readback stalls on out_ready.
module run_sequencer #(
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic           clk,
    input  logic           reset,
    run_sequencer_if.slave bus
);
    localparam int              TW      = $clog2(TIMEOUT);
    localparam logic [7:0]      LB      = 8'(LOAD_BASE);
    localparam logic [7:0]      RB      = 8'(RES_BASE);
    localparam logic [8:0]      LD_LAST = 9'(LOAD_LEN - 1);
    localparam logic [8:0]      RD_LAST = 9'(RES_LEN - 1);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CRST, S_RUN, S_READ, S_DRAIN, S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [8:0]    r_ld_idx;
    logic [8:0]    r_rd_idx;
    logic [TW-1:0] r_tcnt;
    logic          r_timeout;
    logic          r_out_valid;
    logic [7:0]    r_out_data;

    logic w_in_hs;
    logic w_rd_load;
    logic w_out_hs;
    logic w_done_ok;
    logic w_tmo;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        w_in_hs         = bus.in_valid && (r_state == S_LOAD);
        w_rd_load       = (r_state == S_READ) && (!r_out_valid || bus.out_ready);
        w_out_hs        = r_out_valid && bus.out_ready;
        // A done left over from the previous run is not trusted on the first RUN cycle.
        w_done_ok       = (r_state == S_RUN) && bus.core_done && (r_tcnt != '0);
        w_tmo           = (r_state == S_RUN) && !w_done_ok && (r_tcnt == T_LAST);

        bus.in_ready    = (r_state == S_LOAD);
        bus.mem_wr_en   = w_in_hs;
        bus.mem_wr_dat  = bus.in_data;
        bus.mem_sel     = !((r_state == S_CRST) || (r_state == S_RUN));
        bus.mem_addr    = 8'h00;
        bus.core_reset  = reset || (r_state == S_CRST);
        bus.core_req    = (r_state == S_RUN);
        bus.out_valid   = r_out_valid;
        bus.out_data    = r_out_data;
        bus.busy        = !((r_state == S_IDLE) || (r_state == S_FINISH));
        bus.finished    = (r_state == S_FINISH);
        bus.timeout     = r_timeout;

        case (r_state)
            S_IDLE, S_FINISH: if (bus.start) w_next = S_LOAD;
            S_LOAD: begin
                bus.mem_addr = LB + r_ld_idx[7:0];
                if (w_in_hs && (r_ld_idx == LD_LAST)) w_next = S_CRST;
            end
            S_CRST:  w_next = S_RUN;
            S_RUN: begin
                if (w_done_ok)  w_next = S_READ;
                else if (w_tmo) w_next = S_FINISH;
            end
            S_READ: begin
                bus.mem_addr = RB + r_rd_idx[7:0];
                if (w_rd_load && (r_rd_idx == RD_LAST)) w_next = S_DRAIN;
            end
            S_DRAIN: if (w_out_hs) w_next = S_FINISH;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_idx    <= '0;
            r_rd_idx    <= '0;
            r_tcnt      <= '0;
            r_timeout   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    r_ld_idx    <= '0;
                    r_rd_idx    <= '0;
                    r_tcnt      <= '0;
                    r_out_valid <= 1'b0;
                    if (bus.start) r_timeout <= 1'b0;
                end
                S_LOAD: if (w_in_hs) r_ld_idx <= r_ld_idx + 9'd1;
                S_RUN: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (w_tmo) r_timeout <= 1'b1;
                end
                S_READ: if (w_rd_load) begin
                    r_out_data  <= bus.mem_rd_dat;
                    r_out_valid <= 1'b1;
                    r_rd_idx    <= r_rd_idx + 9'd1;
                end
                S_DRAIN: if (w_out_hs) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer: event-timeline model of the run checked every cycle,
// plus directed scenarios (nominal, backpressure, timeout, stale done, reset mid-load, address wrap).
module tb_run_sequencer;
    localparam int LB = 0;
    localparam int LL = 64;
    localparam int RB = 250;
    localparam int RL = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    logic [7:0] mem [256];
    logic [7:0] model_mem [256];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] in_q [$];
    logic [7:0] res_q [$];
    int in_pct, out_pct, done_dly, core_cnt;
    logic stale;

    // model: run timeline
    bit run_on, ended, to_flag, rst_prev;
    int wr_cnt, t_lastwr, rq_cnt, t_end, out_cnt, t_lasths, t_start;
    // observations of the DUT in the current run
    int d_wr, d_crst, d_req, d_ov, d_first_rdy, d_first_req, d_first_ov, d_last_hs, d_last_wr, d_first_addr;

    run_sequencer_if bus();

    run_sequencer #(
        .LOAD_BASE(LB), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    assign bus.mem_rd_dat = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_dat;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        d_wr = 0; d_crst = 0; d_req = 0; d_ov = 0; d_first_rdy = -1; d_first_req = -1;
        d_first_ov = -1; d_last_hs = -1; d_last_wr = -1; d_first_addr = -1;
        res_q.delete();
    endtask

    task automatic monitor();
        bit in_rdy_e, crst_e, req_e, ov_e, fin_e, busy_e, to_e;
        cyc++;
        in_rdy_e = run_on && wr_cnt < LL;
        crst_e   = run_on && wr_cnt == LL && cyc == t_lastwr + 1;
        req_e    = run_on && wr_cnt == LL && cyc >= t_lastwr + 2 && !ended;
        ov_e     = run_on && ended && !to_flag && cyc >= t_end + 2 && out_cnt < RL;
        fin_e    = run_on && ended && (to_flag ? (cyc >= t_end + 1) : (out_cnt == RL && cyc >= t_lasths + 1));
        busy_e   = run_on && !fin_e;
        to_e     = run_on && to_flag && cyc >= t_end + 1;

        chk("in_ready",   bus.in_ready,   in_rdy_e);
        chk("mem_wr_en",  bus.mem_wr_en,  bus.in_valid && in_rdy_e);
        chk("mem_wr_dat", bus.mem_wr_dat, bus.in_data);
        chk("core_reset", bus.core_reset, reset || crst_e);
        chk("core_req",   bus.core_req,   req_e);
        chk("mem_sel",    bus.mem_sel,    !(crst_e || req_e));
        chk("out_valid",  bus.out_valid,  ov_e);
        chk("busy",       bus.busy,       busy_e);
        chk("finished",   bus.finished,   fin_e);
        chk("timeout",    bus.timeout,    to_e);
        if (in_rdy_e) chk("load_addr", bus.mem_addr, (LB + wr_cnt) % 256);
        if (ov_e)     chk("out_data",  bus.out_data, model_mem[(RB + out_cnt) % 256]);
        if (rst_prev) begin
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_out_data", bus.out_data, 0);
        end

        if (bus.in_ready && d_first_rdy < 0) d_first_rdy = cyc;
        if (bus.mem_wr_en) begin
            if (d_wr == 0) d_first_addr = bus.mem_addr;
            d_wr++;
            d_last_wr = cyc;
        end
        if (bus.core_reset && !reset) d_crst++;
        if (bus.core_req) begin
            if (d_req == 0) d_first_req = cyc;
            d_req++;
        end
        if (bus.out_valid) begin
            if (d_ov == 0) d_first_ov = cyc;
            d_ov++;
            if (bus.out_ready) begin
                res_q.push_back(bus.out_data);
                d_last_hs = cyc;
            end
        end
        if (bus.in_valid && bus.in_ready && in_q.size() > 0) void'(in_q.pop_front());

        rst_prev = reset;
        if (reset) begin
            run_on = 0;
        end else if (bus.start && !busy_e) begin
            run_on = 1; wr_cnt = 0; ended = 0; to_flag = 0; out_cnt = 0; rq_cnt = 0;
            t_start = cyc; t_lastwr = 0; t_end = 0; t_lasths = 0;
            clear_obs();
        end else if (run_on) begin
            if (bus.in_valid && in_rdy_e) begin
                model_mem[(LB + wr_cnt) % 256] = bus.in_data;
                wr_cnt++;
                t_lastwr = cyc;
            end
            if (req_e) begin
                if (bus.core_done && rq_cnt >= 1) begin
                    ended = 1; t_end = cyc;
                end else if (rq_cnt == TO - 1) begin
                    ended = 1; to_flag = 1; t_end = cyc;
                end
                rq_cnt++;
            end
            if (ov_e && bus.out_ready) begin
                out_cnt++;
                t_lasths = cyc;
            end
        end
    endtask

    task automatic drive();
        if (in_q.size() > 0) begin
            bus.in_valid = (int'($urandom_range(99)) < in_pct);
            bus.in_data  = in_q[0];
        end else begin
            bus.in_valid = 1'($urandom_range(1));
            bus.in_data  = 8'($urandom);
        end
        bus.out_ready = (int'($urandom_range(99)) < out_pct);
        if (bus.core_req) begin
            core_cnt++;
            bus.core_done = (core_cnt == 1) ? stale : (done_dly > 0 && core_cnt >= done_dly);
        end else begin
            core_cnt = 0;
            bus.core_done = stale;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int budget, input bit spur);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (spur && k == 30) bus.start = 1'b1;
            if (spur && k == 35) bus.start = 1'b0;
            step();
            if (bus.finished) break;
        end
        chk("reached_finish", bus.finished, 1);
        step();
    endtask

    task automatic image_chk(input string nm);
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != model_mem[i]) n++;
        chk(nm, n, 0);
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        bus.out_ready = 1'b0; bus.core_done = 1'b0;
        in_pct = 100; out_pct = 100; done_dly = 10; stale = 1'b0; core_cnt = 0;
        run_on = 0; ended = 0; to_flag = 0; rst_prev = 0;
        wr_cnt = 0; t_lastwr = 0; rq_cnt = 0; t_end = 0; out_cnt = 0; t_lasths = 0; t_start = 0;
        clear_obs();
        for (int i = 0; i < 256; i++) model_mem[i] = pat(i);
        repeat (3) step();
        mem_init = 1'b0;
        reset = 1'b0;
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_sel", bus.mem_sel, 1);

        // nominal run, bytes 0x00..0x3F, done on 10th RUN cycle
        for (int i = 0; i < LL; i++) in_q.push_back(8'(i));
        run(400, 0);
        chk("nom_writes", d_wr, 64);
        chk("nom_first_addr", d_first_addr, 0);
        chk("nom_crst_pulses", d_crst, 1);
        chk("nom_run_cycles", d_req, 10);
        chk("nom_start_to_ready", d_first_rdy - t_start, 1);
        chk("nom_lastwr_to_req", d_first_req - d_last_wr, 2);
        chk("nom_done_to_valid", d_first_ov - (d_first_req + d_req - 1), 2);
        chk("nom_throughput", d_last_hs - d_first_ov, RL - 1);
        chk("nom_res_count", res_q.size(), RL);
        if (res_q.size() == RL) begin
            chk("nom_res_250", res_q[0], 8'hA0);
            chk("nom_res_255", res_q[5], 8'hA5);
            chk("nom_res_wrap0", res_q[6], 8'h00);
            chk("nom_res_wrap1", res_q[7], 8'h01);
        end
        chk("nom_timeout", bus.timeout, 0);
        image_chk("nom_image");

        // random backpressure on both sides, spurious start while busy
        in_pct = 50; out_pct = 50; done_dly = int'($urandom_range(12, 2));
        for (int i = 0; i < LL; i++) in_q.push_back(8'($urandom));
        run(1500, 1);
        chk("bp_writes", d_wr, 64);
        chk("bp_crst_pulses", d_crst, 1);
        chk("bp_run_cycles", d_req, done_dly);
        chk("bp_res_count", res_q.size(), RL);
        image_chk("bp_image");

        // timeout: done stuck low
        in_pct = 100; out_pct = 100; done_dly = 0;
        for (int i = 0; i < LL; i++) in_q.push_back(8'($urandom));
        run(400, 0);
        chk("to_run_cycles", d_req, 16);
        chk("to_no_valid", d_ov, 0);
        chk("to_flag", bus.timeout, 1);
        chk("to_mem_sel", bus.mem_sel, 1);
        image_chk("to_image");

        // stale done entering RUN must not end the run on its first cycle
        stale = 1'b1; done_dly = 3;
        for (int i = 0; i < LL; i++) in_q.push_back(8'($urandom));
        run(400, 0);
        stale = 1'b0;
        chk("stale_run_cycles", d_req, 3);
        chk("stale_timeout_cleared", bus.timeout, 0);
        chk("stale_res_count", res_q.size(), RL);

        // reset after 10 loaded bytes, then a fresh run
        for (int i = 0; i < LL; i++) in_q.push_back(8'($urandom));
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (d_wr >= 10) break;
        end
        chk("rml_ten_bytes", d_wr, 10);
        reset = 1'b1;
        step();
        step();
        chk("rml_in_ready", bus.in_ready, 0);
        chk("rml_mem_sel", bus.mem_sel, 1);
        chk("rml_busy", bus.busy, 0);
        chk("rml_core_reset", bus.core_reset, 1);
        chk("rml_out_data", bus.out_data, 0);
        reset = 1'b0;
        step();
        chk("rml_core_reset_low", bus.core_reset, 0);
        in_q.delete();
        for (int i = 0; i < LL; i++) in_q.push_back(8'(8'h40 + i));
        run(400, 0);
        chk("rml_first_addr", d_first_addr, LB);
        chk("rml_writes", d_wr, 64);
        chk("rml_res_count", res_q.size(), RL);
        if (res_q.size() == RL) begin
            chk("rml_res_wrap0", res_q[6], 8'h40);
            chk("rml_res_wrap1", res_q[7], 8'h41);
        end
        image_chk("rml_image");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
